// File: rtl/nv_ram_rwsp_param_if.sv
// Bus bundle for the parametrised 1R1W registered-read RAM model:
// read address/enables, write port, registered read data and the power-down bus.
interface nv_ram_rwsp_param_if #(
    parameter int unsigned AW         = 5,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MASK_WIDTH = 4
);
    logic [AW-1:0]         ra;
    logic                  re;
    logic                  ore;
    logic [WIDTH-1:0]      dout;
    logic                  dout_vld;
    logic [AW-1:0]         wa;
    logic                  we;
    logic [MASK_WIDTH-1:0] wmask;
    logic [WIDTH-1:0]      di;
    logic [31:0]           pwrbus_ram_pd;

    modport master (
        output ra, re, ore, wa, we, wmask, di, pwrbus_ram_pd,
        input  dout, dout_vld
    );

    modport slave (
        input  ra, re, ore, wa, we, wmask, di, pwrbus_ram_pd,
        output dout, dout_vld
    );
endinterface

// File: rtl/nv_ram_rwsp_param.sv
// Parametrised 1R1W RAM with registered read (address register then output register),
// lane-masked writes, optional write-to-read forwarding and out-of-range protection.
module nv_ram_rwsp_param #(
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned AW         = 5,
    parameter int unsigned MASK_WIDTH = 4,
    parameter int unsigned BYPASS     = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    nv_ram_rwsp_param_if.slave    bus
);
    localparam int unsigned LW      = WIDTH / MASK_WIDTH;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ra_d;
    logic             s1_vld;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] next_data;
    logic [WIDTH-1:0] dout_q;
    logic             dout_vld_q;
    logic             wr_ok;
    logic             rd_ok;
    logic             fwd;
    logic             unused_pwr;

    // Power bus is carried through for wrapper compatibility only.
    assign unused_pwr = ^bus.pwrbus_ram_pd;

    assign wr_ok = bus.we && ({1'b0, bus.wa} < DEPTH_W);
    assign rd_ok = {1'b0, ra_d} < DEPTH_W;
    assign fwd   = (BYPASS != 0) && wr_ok && (bus.wa == ra_d) && bus.ore;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int unsigned i = 0; i < MASK_WIDTH; i++) begin
                if (bus.wmask[i]) begin
                    mem[bus.wa][i*LW +: LW] <= bus.di[i*LW +: LW];
                end
            end
        end
    end

    always_comb begin
        rdata     = rd_ok ? mem[ra_d] : '0;
        next_data = rdata;
        // Forwarded word: written lanes from di, the rest from the stored word.
        if (fwd) begin
            for (int unsigned i = 0; i < MASK_WIDTH; i++) begin
                if (bus.wmask[i]) begin
                    next_data[i*LW +: LW] = bus.di[i*LW +: LW];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ra_d   <= '0;
            s1_vld <= 1'b0;
        end else if (bus.re) begin
            ra_d   <= bus.ra;
            s1_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else if (bus.ore) begin
            dout_q     <= next_data;
            dout_vld_q <= s1_vld;
        end
    end

    assign bus.dout     = dout_q;
    assign bus.dout_vld = dout_vld_q;
endmodule
